// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default operand width and FSM state encoding.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder.
//   master: drives start, a, b, c_in; observes busy, done, sum, c_out
//   slave : the adder side of the same signals
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );

endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell.
//   a, b, c_in : addend bits and carry-in
//   sum, c_out : sum bit and carry-out
module Full_Adder (
  output logic sum,
  output logic c_out,
  input  logic a,
  input  logic b,
  input  logic c_in
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, result valid on a one-cycle done pulse.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : start/a/b/c_in request, busy/done/sum/c_out result (slave side)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_done;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c_out;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_sr_nxt;

  Full_Adder u_fa (
    .sum   (w_fa_sum),
    .c_out (w_fa_cout),
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c_in  (r_carry)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_sum_sr_nxt = (r_sum_sr >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

  // State register, with busy/done registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:                 w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done line up with the state register
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_SHIFT: w_busy_nxt = 1'b1;
      ST_DONE:  w_done_nxt = 1'b1;
      default:  ;
    endcase
  end

  // Operand/result shift registers, carry and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_c_out  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_carry  <= bus.c_in;
            r_cnt    <= '0;
            r_sum_sr <= '0;
          end
        end
        ST_SHIFT: begin
          r_sum_sr <= w_sum_sr_nxt;
          r_carry  <= w_fa_cout;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Visible result changes only when the final bit completes
          if (w_last) begin
            r_sum   <= w_sum_sr_nxt;
            r_c_out <= w_fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with an expected-result scoreboard.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_chk  = 0;
  int         n_bad  = 0;
  int         n_done = 0;
  int         cyc    = 0;
  logic [W:0] q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    logic [W:0] exp;
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      n_done++;
      check_eq("busy_done_excl", 64'(bus.busy), 64'(0));
      check_eq("pending_nonempty", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        exp = q.pop_front();
        check_eq("result", 64'({bus.c_out, bus.sum}), 64'(exp));
      end
    end
  end

  // Waits (bounded) for done; called #1 after a posedge, returns edges counted
  task automatic wait_done(output int lat, output logic seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < int'(W) + 6; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Issues one addition from IDLE (call #1 after a posedge); returns done latency
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output int lat);
    logic seen;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = ci;
    bus.start = 1'b1;
    q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(ci));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.c_in  = 1'($urandom);
    wait_done(lat, seen);
    check_eq("done_seen", 64'(seen), 64'(1));
  endtask

  initial begin
    int         lat;
    int         n0;
    int         t1;
    int         t2;
    logic       seen;
    logic [W:0] first_res;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",  64'(bus.busy),  64'(0));
    check_eq("rst_done",  64'(bus.done),  64'(0));
    check_eq("rst_sum",   64'(bus.sum),   64'(0));
    check_eq("rst_c_out", 64'(bus.c_out), 64'(0));

    // Release and start immediately: first edge after release must accept it
    rst_n = 1'b1;
    run_add(8'h5A, 8'h3C, 1'b0, lat);
    check_eq("lat_5a3c", 64'(lat), 64'(W));
    @(posedge clk); #1;
    check_eq("idle_after_done", 64'({bus.busy, bus.done}), 64'(0));

    run_add(8'hFF, 8'h01, 1'b0, lat);
    @(posedge clk); #1;
    run_add(8'hFF, 8'hFF, 1'b1, lat);
    check_eq("lat_ffff", 64'(lat), 64'(W));
    @(posedge clk); #1;

    // Second start while shifting is ignored
    n0        = n_done;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.c_in  = 1'b0;
    bus.start = 1'b1;
    q.push_back(9'h046);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, seen);
    check_eq("ign_done_seen", 64'(seen), 64'(1));
    repeat (4) @(posedge clk);
    #1;
    check_eq("ign_one_pulse", 64'(n_done - n0), 64'(1));
    check_eq("ign_no_restart", 64'(bus.busy), 64'(0));

    // Reset in the middle of an addition aborts it
    bus.a     = 8'h33;
    bus.b     = 8'h44;
    bus.c_in  = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy",  64'(bus.busy),  64'(0));
    check_eq("abort_sum",   64'(bus.sum),   64'(0));
    check_eq("abort_c_out", 64'(bus.c_out), 64'(0));
    n0 = n_done;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_no_done", 64'(n_done - n0), 64'(0));
    check_eq("abort_sum_hold", 64'(bus.sum), 64'(0));
    run_add(8'h81, 8'h7F, 1'b1, lat);
    check_eq("lat_after_abort", 64'(lat), 64'(W));
    @(posedge clk); #1;

    // Back-to-back: start in the IDLE cycle right after done
    first_res = 9'h0C8;
    run_add(8'h64, 8'h64, 1'b0, lat);
    t1 = cyc;
    @(posedge clk); #1;
    bus.a     = 8'h0F;
    bus.b     = 8'hF0;
    bus.c_in  = 1'b1;
    bus.start = 1'b1;
    q.push_back(9'h100);
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < int'(W) + 6; i++) begin
      check_eq("b2b_hold", 64'({bus.c_out, bus.sum}), 64'(first_res));
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    t2 = cyc;
    check_eq("b2b_done_seen", 64'(seen), 64'(1));
    check_eq("b2b_gap", 64'(t2 - t1), 64'(W + 2));
    @(posedge clk); #1;

    // Random operands
    for (int k = 0; k < 1000; k++) begin
      run_add(W'($urandom), W'($urandom), 1'($urandom), lat);
      @(posedge clk); #1;
    end
    check_eq("queue_drained", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
